// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: shared fetch-sequencer types and constants
package fetch_pc_unit_pkg;
  typedef enum logic [1:0] {FETCH, EXEC, ERROR} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0] INSTR_ALIGN = 2'b00;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: next-PC adder with misaligned-target detection
module pc_next_calc
  import fetch_pc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] incremento,
  output logic [31:0] nxt,
  output logic        misaligned
);
  assign nxt = pc + incremento;
  assign misaligned = nxt[1:0] != INSTR_ALIGN;
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register, fetch handshake FSM and retired-instruction counter
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Incremento,
  input  logic        Avanzar,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] Instruccion,
  output logic        Instr_valido,
  output logic [31:0] PC,
  output logic        Error_alin,
  output logic [31:0] Cuenta_instr
);
  state_t state;
  logic [31:0] nxt;
  logic mis;
  pc_next_calc u_calc (
    .pc(PC),
    .incremento(Incremento),
    .nxt(nxt),
    .misaligned(mis)
  );
  // reset gates the request so an abandoned fetch is never presented
  assign mem_req = state == FETCH && !reset;
  assign mem_addr = PC;
  assign Instr_valido = state == EXEC;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      PC <= RESET_PC;
      Instruccion <= NOP;
      Error_alin <= 1'b0;
      Cuenta_instr <= 32'd0;
    end else begin
      case (state)
        FETCH: if (mem_ack) begin
          Instruccion <= mem_rdata;
          state <= EXEC;
        end
        EXEC: if (Avanzar) begin
          if (mis) begin
            Error_alin <= 1'b1;
            state <= ERROR;
          end else begin
            PC <= nxt;
            Cuenta_instr <= Cuenta_instr + 32'd1;
            state <= FETCH;
          end
        end
        default: state <= ERROR;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: table-driven directed checks plus stall/error sequences
module tb_fetch_pc_unit;
  logic clk = 0;
  logic reset, Avanzar, mem_ack, mem_req, Instr_valido, Error_alin;
  logic [31:0] Incremento, mem_addr, mem_rdata, Instruccion, PC, Cuenta_instr;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset), .Incremento(Incremento), .Avanzar(Avanzar),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .Instruccion(Instruccion), .Instr_valido(Instr_valido), .PC(PC),
    .Error_alin(Error_alin), .Cuenta_instr(Cuenta_instr)
  );

  typedef struct {
    logic rst, ack, av;
    logic [31:0] rdata, inc;
    logic req, iv, err;
    logic [31:0] addr, instr, cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic ack, logic [31:0] rdata, logic av,
                              logic [31:0] inc, logic req, logic [31:0] addr, logic iv,
                              logic [31:0] instr, logic err, logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.av = av; v.inc = inc;
    v.req = req; v.addr = addr; v.iv = iv; v.instr = instr; v.err = err; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  task automatic drive(input logic rst, input logic ack, input logic [31:0] rdata,
                       input logic av, input logic [31:0] inc);
    reset = rst; mem_ack = ack; mem_rdata = rdata; Avanzar = av; Incremento = inc;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst ack rdata av inc | req addr iv instr err cnt (state after the edge)
    tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h100,      0, 32'h13,       0, 0));
    tbl.push_back(mk(0, 1, 32'h00A00093, 0, 32'h0,        0, 32'h100,      1, 32'h00A00093, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,        1, 32'h4,        1, 32'h104,      0, 32'h00A00093, 0, 1));
    tbl.push_back(mk(0, 1, 32'h11111111, 0, 32'h0,        0, 32'h104,      1, 32'h11111111, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,        1, 32'hFFFFFF1C, 1, 32'h20,       0, 32'h11111111, 0, 2));
    tbl.push_back(mk(0, 1, 32'h22222222, 0, 32'h0,        0, 32'h20,       1, 32'h22222222, 0, 2));
    tbl.push_back(mk(0, 0, 32'h0,        1, 32'hFFFFFFF0, 1, 32'h10,       0, 32'h22222222, 0, 3));
    tbl.push_back(mk(0, 0, 32'h0,        1, 32'h4,        1, 32'h10,       0, 32'h22222222, 0, 3));
    tbl.push_back(mk(0, 1, 32'h33333333, 0, 32'h0,        0, 32'h10,       1, 32'h33333333, 0, 3));
    tbl.push_back(mk(0, 1, 32'h44444444, 0, 32'h0,        0, 32'h10,       1, 32'h33333333, 0, 3));
    tbl.push_back(mk(0, 0, 32'h0,        1, 32'hFFFFFFF8, 1, 32'h8,        0, 32'h33333333, 0, 4));
    tbl.push_back(mk(0, 1, 32'h55555555, 0, 32'h0,        0, 32'h8,        1, 32'h55555555, 0, 4));
    tbl.push_back(mk(0, 0, 32'h0,        1, 32'h6,        0, 32'h8,        0, 32'h55555555, 1, 4));
    tbl.push_back(mk(0, 1, 32'h0,        1, 32'h4,        0, 32'h8,        0, 32'h55555555, 1, 4));
    tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h100,      0, 32'h13,       0, 0));
    tbl.push_back(mk(1, 1, 32'h66666666, 0, 32'h0,        0, 32'h100,      0, 32'h13,       0, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      0, 32'h13,       0, 0));
    tbl.push_back(mk(0, 1, 32'h77777777, 0, 32'h0,        0, 32'h100,      1, 32'h77777777, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,        1, 32'h4,        0, 32'h100,      0, 32'h13,       0, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      0, 32'h13,       0, 0));
    tbl.push_back(mk(0, 1, 32'h88888888, 0, 32'h0,        0, 32'h100,      1, 32'h88888888, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,        1, 32'hFFFFFEFC, 1, 32'hFFFFFFFC, 0, 32'h88888888, 0, 1));
    tbl.push_back(mk(0, 1, 32'h99999999, 0, 32'h0,        0, 32'hFFFFFFFC, 1, 32'h99999999, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,        1, 32'h4,        1, 32'h0,        0, 32'h99999999, 0, 2));

    drive(1, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ack, tbl[i].rdata, tbl[i].av, tbl[i].inc);
      step();
      chk($sformatf("v%0d mem_req", i), {31'd0, mem_req}, {31'd0, tbl[i].req});
      chk($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("v%0d PC", i), PC, tbl[i].addr);
      chk($sformatf("v%0d Instr_valido", i), {31'd0, Instr_valido}, {31'd0, tbl[i].iv});
      chk($sformatf("v%0d Instruccion", i), Instruccion, tbl[i].instr);
      chk($sformatf("v%0d Error_alin", i), {31'd0, Error_alin}, {31'd0, tbl[i].err});
      chk($sformatf("v%0d Cuenta_instr", i), Cuenta_instr, tbl[i].cnt);
    end

    // fetch stall: request held at PC 0 for 5 cycles, then a single ack
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 32'hDEADBEEF, 0, 0);
      step();
      chk("stall mem_req", {31'd0, mem_req}, 32'd1);
      chk("stall mem_addr", mem_addr, 32'h0);
      chk("stall Instr_valido", {31'd0, Instr_valido}, 32'd0);
    end
    drive(0, 1, 32'h0000ABCD, 0, 0);
    #1;
    chk("ack cycle Instr_valido", {31'd0, Instr_valido}, 32'd0);
    chk("ack cycle mem_req", {31'd0, mem_req}, 32'd1);
    step();
    chk("post ack Instr_valido", {31'd0, Instr_valido}, 32'd1);
    chk("post ack Instruccion", Instruccion, 32'h0000ABCD);

    // exec stall: Instruccion held while Avanzar is low
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 32'h12345678, 0, 32'h4);
      step();
      chk("exec stall Instruccion", Instruccion, 32'h0000ABCD);
      chk("exec stall Instr_valido", {31'd0, Instr_valido}, 32'd1);
      chk("exec stall mem_req", {31'd0, mem_req}, 32'd0);
    end

    // misaligned target from PC 8, then 10 ignored ack/Avanzar pulses
    drive(0, 0, 0, 1, 32'h8);
    step();
    chk("to 8 PC", PC, 32'h8);
    drive(0, 1, 32'h00000013, 0, 0);
    step();
    drive(0, 0, 0, 1, 32'h6);
    step();
    chk("misalign Error_alin", {31'd0, Error_alin}, 32'd1);
    chk("misalign PC", PC, 32'h8);
    chk("misalign Cuenta_instr", Cuenta_instr, 32'd3);
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 32'hFFFFFFFF, 1, 32'h4);
      step();
      chk("error mem_req", {31'd0, mem_req}, 32'd0);
      chk("error Instr_valido", {31'd0, Instr_valido}, 32'd0);
      chk("error Error_alin", {31'd0, Error_alin}, 32'd1);
      drive(0, 0, 0, 0, 0);
      step();
      chk("error idle mem_req", {31'd0, mem_req}, 32'd0);
    end
    chk("error PC held", PC, 32'h8);
    drive(1, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    chk("post reset Error_alin", {31'd0, Error_alin}, 32'd0);
    chk("post reset mem_req", {31'd0, mem_req}, 32'd1);
    chk("post reset mem_addr", mem_addr, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter register and instruction-fetch sequencer for the single-issue RISC-V core. Holds the current PC, fetches the instruction word from instruction memory over a request/acknowledge handshake, and presents it as `Instruccion` to the branch-offset mux and decode. When the instruction completes, it adds the mux's 32-bit increment `Y` (4, or the shifted sign-extended branch offset) to the PC and fetches again. Misaligned targets halt fetch, and a retired-instruction counter is kept.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1: sole clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `Incremento`  in  32: PC increment from the offset mux; two's complement.
- `Avanzar`  in  1: the current instruction is finished and `Incremento` is valid this cycle.
- `mem_req`  out  1: fetch request.
- `mem_addr`  out  32: fetch address; equals `PC`.
- `mem_ack`  in  1: request accepted; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32: fetched instruction word.
- `Instruccion`  out  32: registered current instruction.
- `Instr_valido`  out  1: `Instruccion` is valid and awaiting `Avanzar`.
- `PC`  out  32: address of `Instruccion` or of the fetch in flight.
- `Error_alin`  out  1: sticky misaligned-target flag.
- `Cuenta_instr`  out  32: retired-instruction count.

## Operation
- FSM states: FETCH, EXEC, ERROR.
- Reset applies in the cycle `reset`=1 and overrides all other inputs:
  - PC=RESET_PC, state=FETCH, `Instruccion`=32'h0000_0013 (NOP), `Instr_valido`=0, `Error_alin`=0, `Cuenta_instr`=0.
- FETCH:
  - `mem_req` = 1 and `reset` = 0; `mem_addr` = PC, held stable until `mem_ack`.
  - On `mem_ack`=1: register `mem_rdata` into `Instruccion`, then go to EXEC.
  - `Avanzar` is ignored in FETCH.
- EXEC:
  - `Instr_valido`=1 and `mem_req`=0; `mem_ack` is ignored.
  - On `Avanzar`=1: nxt = PC + `Incremento`, modulo 2^32 (wrap-around, no overflow flag).
    - If nxt[1:0] = 0: PC <= nxt, `Cuenta_instr` += 1 (wraps at 2^32), go to FETCH.
    - Otherwise: PC is unchanged, `Error_alin` <= 1, `Cuenta_instr` is not incremented, go to ERROR.
- ERROR: `mem_req`=0, `Instr_valido`=0. Only `reset` exits this state.
- Negative increments are legal; for example, PC 0x10 + 0xFFFF_FFF8 gives 0x08.

## Timing
- `mem_req`, `mem_addr`, `Instr_valido` and `PC` are decoded from registered state with no input-to-output combinational path. The only exception is the `reset` gating of `mem_req`.
- Fetch latency: `Instr_valido` rises the cycle after the `mem_ack` cycle.
- Best-case throughput: 2 cycles per instruction (`mem_ack` in the first FETCH cycle, `Avanzar` in the first EXEC cycle).
- Stalls:
  - `mem_ack` low keeps the unit in FETCH indefinitely, with the request held.
  - `Avanzar` low keeps it in EXEC indefinitely, with `Instruccion` held.
- `Incremento` is sampled only in the `Avanzar` cycle.
- Reset during FETCH: the fetch is abandoned, and any `mem_ack` in that cycle is ignored. The first post-reset request goes to RESET_PC in the cycle after reset falls.
- Reset during EXEC: a simultaneous `Avanzar` is ignored.

## Structure
- Shared core package holds:
  - the state enumeration (FETCH/EXEC/ERROR);
  - the NOP constant 32'h0000_0013;
  - the `INSTR_ALIGN` mask 2'b00.
- One combinational sub-module, `pc_next_calc`:
  - inputs PC and `Incremento`;
  - outputs nxt and a misaligned flag.
- The FSM, registers and counter stay in `fetch_pc_unit`.

## Test plan
- Reset with RESET_PC=0x100; release; `mem_ack` in the first cycle with rdata 0x00A00093; `Avanzar` with `Incremento`=4 → `mem_addr`=0x100, `Instruccion`=0x00A00093 one cycle later, next request at 0x104, `Cuenta_instr`=1.
- Branch back from PC=0x20 with `Incremento`=0xFFFF_FFF0 → next `mem_addr`=0x10.
- Hold `mem_ack` low 5 cycles, then pulse it → `mem_req` high and `mem_addr` constant throughout; `Instr_valido` rises exactly one cycle after the ack.
- From PC=0x8, `Avanzar` with `Incremento`=0x6 → `Error_alin`=1, state ERROR, `mem_req` stays 0 through 10 further `mem_ack`/`Avanzar` pulses; after reset, `Error_alin`=0.
- Assert `reset` in the same cycle as `mem_ack` (and separately as `Avanzar`) → no capture or PC update; `Instruccion`=0x13, PC=RESET_PC.
- PC=0xFFFF_FFFC with `Incremento`=4 → PC wraps to 0x0000_0000 and `Cuenta_instr` increments.
